// File: rtl/sam_stream_driver.sv
// Sequencer for the SAM serial interface: shifts one configuration word out while mode=1,
// then sends each message bit as a high/low pulse pair of length T_LONG/T_SHORT on str.
module sam_stream_driver #(
  parameter int KEY_W   = 8,
  parameter int T_LONG  = 20,
  parameter int T_SHORT = 12,
  parameter int GAP     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_n,
  input  logic [KEY_W-1:0] cfg_d,
  input  logic [KEY_W-1:0] cfg_capsn,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [KEY_W-1:0] msg_data,
  output logic             str,
  output logic             mode,
  output logic             configured,
  output logic             busy
);

  localparam int CFG_W = 4 + 2 * KEY_W;

  typedef enum logic [3:0] {
    S_IDLE, S_READY, S_CFG_LEAD, S_CFG_SHIFT, S_CFG_TAIL,
    S_GAP, S_MSG_HI, S_MSG_LO, S_STOP_HI, S_STOP_LO
  } state_t;

  state_t           state_r;
  logic [4:0]       dur_cnt_r;
  logic [4:0]       bit_cnt_r;
  logic [CFG_W-1:0] cfg_sr_r;
  logic [3:0]       n_r;
  logic [KEY_W-1:0] msg_sr_r;
  logic             cfg_ready_r;
  logic             msg_ready_r;
  logic             configured_r;
  logic             busy_r;
  logic             str_r;
  logic             mode_r;
  logic             str_s;
  logic             mode_s;
  logic [4:0]       n_eff_s;
  logic [4:0]       shamt_s;
  logic [KEY_W-1:0] msg_load_s;
  logic             cfg_acc_s;
  logic             msg_acc_s;

  // A simultaneous configuration request wins, so the message handshake is masked that cycle.
  assign msg_ready  = msg_ready_r & ~cfg_valid;
  assign cfg_ready  = cfg_ready_r;
  assign configured = configured_r;
  assign busy       = busy_r;
  assign str        = str_r;
  assign mode       = mode_r;

  assign cfg_acc_s  = cfg_valid & cfg_ready_r;
  assign msg_acc_s  = msg_valid & msg_ready;
  assign shamt_s    = 5'(KEY_W) - n_eff_s;
  assign msg_load_s = msg_data << shamt_s;

  // Effective message length: zero or oversize lengths fall back to the full word.
  always_comb begin
    n_eff_s = {1'b0, n_r};
    if ((n_r == 4'd0) || ({1'b0, n_r} > 5'(KEY_W))) begin
      n_eff_s = 5'(KEY_W);
    end else begin
      n_eff_s = {1'b0, n_r};
    end
  end

  // Line levels implied by the current state; re-timed onto the falling edge below.
  always_comb begin
    str_s  = 1'b0;
    mode_s = 1'b0;
    case (state_r)
      S_CFG_LEAD:          mode_s = 1'b1;
      S_CFG_SHIFT: begin
        mode_s = 1'b1;
        str_s  = cfg_sr_r[CFG_W-1];
      end
      S_CFG_TAIL:          mode_s = 1'b1;
      S_MSG_HI, S_STOP_HI: str_s  = 1'b1;
      default: begin
        str_s  = 1'b0;
        mode_s = 1'b0;
      end
    endcase
  end

  // Main sequencer: state, duration/bit counters, shift registers and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      dur_cnt_r    <= 5'd0;
      bit_cnt_r    <= 5'd0;
      cfg_sr_r     <= '0;
      n_r          <= 4'd0;
      msg_sr_r     <= '0;
      cfg_ready_r  <= 1'b0;
      msg_ready_r  <= 1'b0;
      configured_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_READY: begin
          if (cfg_acc_s) begin
            cfg_sr_r    <= {cfg_n, cfg_d, cfg_capsn};
            n_r         <= cfg_n;
            state_r     <= S_CFG_LEAD;
            cfg_ready_r <= 1'b0;
            msg_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end else if (msg_acc_s) begin
            msg_sr_r    <= msg_load_s;
            bit_cnt_r   <= n_eff_s - 5'd1;
            dur_cnt_r   <= msg_load_s[KEY_W-1] ? 5'(T_LONG - 1) : 5'(T_SHORT - 1);
            state_r     <= S_MSG_HI;
            cfg_ready_r <= 1'b0;
            msg_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            cfg_ready_r <= 1'b1;
            msg_ready_r <= (state_r == S_READY);
            busy_r      <= 1'b0;
          end
        end
        S_CFG_LEAD: begin
          bit_cnt_r <= 5'(CFG_W - 1);
          state_r   <= S_CFG_SHIFT;
        end
        S_CFG_SHIFT: begin
          cfg_sr_r <= {cfg_sr_r[CFG_W-2:0], 1'b0};
          if (bit_cnt_r == 5'd0) begin
            state_r <= S_CFG_TAIL;
          end else begin
            bit_cnt_r <= bit_cnt_r - 5'd1;
          end
        end
        S_CFG_TAIL: begin
          dur_cnt_r <= 5'(GAP - 1);
          state_r   <= S_GAP;
        end
        S_GAP: begin
          if (dur_cnt_r == 5'd0) begin
            state_r      <= S_READY;
            cfg_ready_r  <= 1'b1;
            msg_ready_r  <= 1'b1;
            configured_r <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            dur_cnt_r <= dur_cnt_r - 5'd1;
          end
        end
        S_MSG_HI: begin
          if (dur_cnt_r == 5'd0) begin
            dur_cnt_r <= msg_sr_r[KEY_W-1] ? 5'(T_SHORT - 1) : 5'(T_LONG - 1);
            state_r   <= S_MSG_LO;
          end else begin
            dur_cnt_r <= dur_cnt_r - 5'd1;
          end
        end
        S_MSG_LO: begin
          if (dur_cnt_r != 5'd0) begin
            dur_cnt_r <= dur_cnt_r - 5'd1;
          end else if (bit_cnt_r == 5'd0) begin
            dur_cnt_r <= 5'(T_SHORT - 1);
            state_r   <= S_STOP_HI;
          end else begin
            msg_sr_r  <= {msg_sr_r[KEY_W-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - 5'd1;
            dur_cnt_r <= msg_sr_r[KEY_W-2] ? 5'(T_LONG - 1) : 5'(T_SHORT - 1);
            state_r   <= S_MSG_HI;
          end
        end
        S_STOP_HI: begin
          if (dur_cnt_r == 5'd0) begin
            dur_cnt_r <= 5'(T_LONG - 1);
            state_r   <= S_STOP_LO;
          end else begin
            dur_cnt_r <= dur_cnt_r - 5'd1;
          end
        end
        S_STOP_LO: begin
          if (dur_cnt_r == 5'd0) begin
            dur_cnt_r <= 5'(GAP - 1);
            state_r   <= S_GAP;
          end else begin
            dur_cnt_r <= dur_cnt_r - 5'd1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cfg_ready_r <= 1'b0;
          msg_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Falling-edge copy of the line levels so SAM's rising-edge sampling sees settled data.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      str_r  <= 1'b0;
      mode_r <= 1'b0;
    end else begin
      str_r  <= str_s;
      mode_r <= mode_s;
    end
  end

endmodule

// File: tb/tb_sam_stream_driver.sv
// Randomized bench for sam_stream_driver: expected str/mode waveforms are built cycle by
// cycle from the protocol rules (bit lists and pulse lengths) and compared at mid-cycle.
module tb_sam_stream_driver;

  localparam int KEY_W   = 8;
  localparam int T_LONG  = 20;
  localparam int T_SHORT = 12;
  localparam int GAP     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_n = 4'd0;
  logic [7:0] cfg_d = 8'd0;
  logic [7:0] cfg_capsn = 8'd0;
  logic       msg_valid = 1'b0;
  logic       msg_ready;
  logic [7:0] msg_data = 8'd0;
  logic       str;
  logic       mode;
  logic       configured;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  logic       cfg_done_m = 1'b0;
  logic [3:0] n_m = 4'd0;
  int         w;

  sam_stream_driver #(.KEY_W(KEY_W), .T_LONG(T_LONG), .T_SHORT(T_SHORT), .GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_d(cfg_d), .cfg_capsn(cfg_capsn),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .str(str), .mode(mode), .configured(configured), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Configure and check the mode window, serial bits, gap and return to READY.
  task automatic do_cfg(input logic [3:0] n, input logic [7:0] d, input logic [7:0] cn,
                        input bit with_msg);
    logic [1:0]  exp_q[$];
    logic [19:0] word;
    int          waits;
    word = {n, d, cn};
    exp_q.push_back(2'b10);
    for (int i = 19; i >= 0; i--) exp_q.push_back({1'b1, word[i]});
    exp_q.push_back(2'b10);
    for (int i = 0; i < GAP; i++) exp_q.push_back(2'b00);
    cfg_n = n; cfg_d = d; cfg_capsn = cn; cfg_valid = 1'b1;
    waits = 0;
    #1;
    while (!cfg_ready && waits < 200) begin
      @(posedge clk); #7; waits++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    if (with_msg) check("msg_ready_prio", 32'(msg_ready), 32'd0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_n = 4'($urandom); cfg_d = 8'($urandom); cfg_capsn = 8'($urandom);
    #5;
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("cfg_wave[%0d]", k), {30'd0, mode, str}, {30'd0, exp_q[k]});
      if (k == 0) begin
        check("cfg_busy", 32'(busy), 32'd1);
        check("cfg_configured_hold", 32'(configured), 32'(cfg_done_m));
        check("cfg_ready_low", 32'(cfg_ready), 32'd0);
      end
      #10;
    end
    check("cfg_end_cfg_ready", 32'(cfg_ready), 32'd1);
    check("cfg_end_msg_ready", 32'(msg_ready), 32'd1);
    check("cfg_end_configured", 32'(configured), 32'd1);
    check("cfg_end_busy", 32'(busy), 32'd0);
    cfg_done_m = 1'b1;
    n_m = n;
  endtask

  // Send one message and check its pulse train, STOP, gap and READY latency.
  task automatic do_msg(input logic [7:0] data, output int waits);
    logic q[$];
    int   neff, longs, run, exp_longs;
    bit   b;
    neff = (n_m == 4'd0 || int'(n_m) > KEY_W) ? KEY_W : int'(n_m);
    longs = 0; run = 0; exp_longs = 0;
    for (int i = neff - 1; i >= 0; i--) begin
      b = data[i];
      if (b) exp_longs++;
      repeat (b ? T_LONG : T_SHORT) q.push_back(1'b1);
      repeat (b ? T_SHORT : T_LONG) q.push_back(1'b0);
    end
    repeat (T_SHORT) q.push_back(1'b1);
    repeat (T_LONG) q.push_back(1'b0);
    repeat (GAP) q.push_back(1'b0);
    msg_data = data; msg_valid = 1'b1;
    waits = 0;
    #1;
    while (!msg_ready && waits < 200) begin
      @(posedge clk); #7; waits++;
    end
    check("msg_ready_wait", 32'(msg_ready), 32'd1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_data = 8'($urandom);
    #5;
    for (int k = 0; k < q.size(); k++) begin
      check($sformatf("msg_wave[%0d]", k), {30'd0, mode, str}, {31'd0, q[k]});
      if (str) run++;
      else begin
        if (run == T_LONG) longs++;
        run = 0;
      end
      if (k == 0) begin
        check("msg_busy", 32'(busy), 32'd1);
        check("msg_ready_low", 32'(msg_ready), 32'd0);
      end
      if (k == q.size() - 1) check("msg_ready_early", 32'(msg_ready), 32'd0);
      #10;
    end
    check("msg_end_ready", 32'(msg_ready), 32'd1);
    check("msg_end_busy", 32'(busy), 32'd0);
    check("msg_long_runs", 32'(longs), 32'(exp_longs));
  endtask

  initial begin
    #23;
    check("rst_str", 32'(str), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_msg_ready", 32'(msg_ready), 32'd0);
    check("rst_configured", 32'(configured), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #6;
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Message request before any configuration must be ignored.
    msg_data = 8'h5A; msg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("early_msg_ready", 32'(msg_ready), 32'd0);
      check("early_str", 32'(str), 32'd0);
      check("early_busy", 32'(busy), 32'd0);
      #9;
    end
    msg_valid = 1'b0;

    do_cfg(4'd3, 8'hFF, 8'hFF, 1'b0);
    do_msg(8'h05, w);
    do_cfg(4'd8, 8'($urandom), 8'($urandom), 1'b0);
    do_msg(8'hA5, w);

    // Configuration and message requested together: configuration wins, message follows.
    msg_data = 8'h3C; msg_valid = 1'b1;
    do_cfg(4'd5, 8'($urandom), 8'($urandom), 1'b1);
    do_msg(8'h3C, w);
    check("both_msg_first_ready", 32'(w), 32'd0);

    do_cfg(4'd0, 8'($urandom), 8'($urandom), 1'b0);
    do_msg(8'($urandom), w);
    do_cfg(4'd12, 8'($urandom), 8'($urandom), 1'b0);
    do_msg(8'($urandom), w);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        bit         wm;
        logic [7:0] md;
        wm = 1'($urandom_range(0, 1));
        md = 8'($urandom);
        if (wm) begin
          msg_data = md; msg_valid = 1'b1;
        end
        do_cfg(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), wm);
        if (wm) begin
          do_msg(md, w);
          check("rnd_msg_first_ready", 32'(w), 32'd0);
        end
      end else begin
        do_msg(8'($urandom), w);
      end
    end

    // Asynchronous reset in the middle of the configuration shift.
    cfg_n = 4'd3; cfg_d = 8'hFF; cfg_capsn = 8'hFF; cfg_valid = 1'b1;
    #1;
    check("rst_mid_accept", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    #55;
    check("rst_mid_pre_mode", 32'(mode), 32'd1);
    check("rst_mid_pre_str", 32'(str), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_str", 32'(str), 32'd0);
    check("rst_mid_mode", 32'(mode), 32'd0);
    check("rst_mid_configured", 32'(configured), 32'd0);
    #3;
    reset = 1'b1;
    cfg_done_m = 1'b0;
    @(posedge clk);
    #6;
    check("rst_rel_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_rel_msg_ready", 32'(msg_ready), 32'd0);
    check("rst_rel_busy", 32'(busy), 32'd0);
    check("rst_rel_mode", 32'(mode), 32'd0);

    do_cfg(4'd4, 8'($urandom), 8'($urandom), 1'b0);
    do_msg(8'($urandom), w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
